instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch unit between the instruction memory and the decode/execute controller. Owns the program counter, issues word reads to memory, buffers returned instructions with their PCs in a small FIFO, and presents them to the controller over a valid/ready handshake. Accepts a single-cycle redirect from the controller for taken branches and jumps, and flushes all buffered and in-flight fetches when one arrives.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of 2 and at least 2.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset; must be word-aligned.

- `clk` in 1: single clock; everything is rising-edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `read_address` out 32: memory read address, equal to `fetch_pc`.
- `funct3` out 3: constant 3'b010 (word read).
- `write_mem` out 1: constant 0.
- `read_data` in 32: memory word for the address presented in the previous cycle.
- `inst_valid` out 1: the FIFO head holds an instruction.
- `inst_ready` in 1: the consumer accepts the head this cycle.
- `inst_data` out 32: instruction at the head.
- `inst_pc` out 32: address of `inst_data`.
- `redirect_valid` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch address; bits [1:0] are ignored and forced to 0.
- `halted` out 1: fetch has stopped on a stop word. Only driven when `FETCH_HALT_ON_ZERO_EN` is defined; otherwise tied to 0.

## Operation
- Registers:
  - `fetch_pc`: 32-bit next fetch address.
  - `pend`: 1-bit flag, a response is due this cycle.
  - `pend_pc`: address of the in-flight read.
  - FIFO: `DEPTH` entries of {pc, inst}, plus a count.
  - `state` ∈ {FETCH, HALTED}.
- Issue condition: `state==FETCH && !redirect_valid && (count + pend) < DEPTH`.
  - On issue: `pend<=1`, `pend_pc<=fetch_pc`, `fetch_pc<=fetch_pc+4` (wraps modulo 2^32).
  - Otherwise: `pend<=0` and `fetch_pc` holds.
- Capture: when `pend==1` and there is no redirect, push {`pend_pc`, `read_data`} into the FIFO.
- Pop: `inst_valid && inst_ready` removes the head. `inst_ready` while empty has no effect. A push and a pop in the same cycle leave `count` unchanged.
- Redirect has top priority. In that cycle:
  - the FIFO is flushed (count<=0);
  - `pend<=0`, so any returning `read_data` is dropped;
  - `fetch_pc<={redirect_pc[31:2],2'b00}`;
  - `state<=FETCH`.
  - A pop asserted in the same cycle counts as accepted; the flush makes it moot.
- The credit rule means a push can never overflow the FIFO.
- FSM:
  - FETCH→HALTED on a stop-word capture (macro only).
  - HALTED→FETCH only on redirect or reset.
  - In HALTED no reads issue, and the FIFO keeps draining normally.
- Reset values (while `rst_n==0` at an edge):
  - `fetch_pc=RESET_PC`, so `read_address=RESET_PC`;
  - `pend=0`, count=0, `inst_valid=0`;
  - `inst_data=0`, `inst_pc=0` (the head entry is cleared);
  - `state=FETCH`, `halted=0`.
- Reset asserted mid-operation discards all buffered and in-flight words.

## Timing
- The memory read has 1-cycle latency: the address presented in cycle N returns as `read_data` in cycle N+1.
- First instruction:
  - reset released before edge 0;
  - address issued in cycle 0;
  - captured at the end of cycle 1;
  - `inst_valid=1` with `inst_pc=RESET_PC` in cycle 2.
- Throughput is one instruction per cycle with `inst_ready` held high and `DEPTH>=3`.
- Redirect latency:
  - redirect in cycle R;
  - `read_address=redirect_pc` in cycle R+1;
  - first new instruction valid in cycle R+3;
  - `inst_valid=0` in cycles R+1 and R+2.
- `inst_*` are FIFO-head registers; there is no combinational path from `inst_ready` to them.

## Configuration
- `FETCH_HALT_ON_ZERO_EN` defined:
  - a captured `read_data==32'h0` is not pushed;
  - `state->HALTED`;
  - `halted=1` from the next cycle until redirect or reset.
- Not defined:
  - the zero word is pushed like any other instruction;
  - the HALTED state is unreachable;
  - `halted` is constant 0.

## Structure
- Package `fetch_pkg`:
  - `XLEN=32`, `PC_STEP=4`, `FUNCT3_LW=3'b010`;
  - `fetch_state_t` enum {FETCH, HALTED};
  - packed struct `fetch_entry_t` {pc, inst}.
- Sub-module `fetch_fifo`: synchronous show-ahead FIFO of `fetch_entry_t`, parameter `DEPTH`, with push/pop/flush inputs and an exposed count. Pointers wrap modulo `DEPTH`.

## Test plan
- **Reset then stream:** `rst_n` low for 2 cycles, memory holds words `0x00100093`, `0x00200113`, `0x00300193` at 0/4/8, `inst_ready=1`.
  - Expect `inst_valid` first in cycle 2 with pc 0, then pcs 4 and 8 on consecutive cycles.
- **Backpressure:** `inst_ready=0` for 10 cycles.
  - Expect count to saturate at 4 and `read_address` to freeze at 0x10.
  - Release `inst_ready`: pcs 0,4,8,0xC,0x10 arrive in order with none lost or duplicated.
- **Redirect:** `redirect_valid=1`, `redirect_pc=0x103` while 3 entries are buffered and one read is in flight.
  - Expect `read_address=0x100` next cycle, `inst_valid=0` for 2 cycles, then pc 0x100.
  - No stale pc 0xC/0x10 may appear.
- **Wrap:** redirect to 0xFFFF_FFFC.
  - Expect instructions at pc 0xFFFF_FFFC then pc 0x0000_0000.
- **Stop word with the macro:** word 0 at address 0x8.
  - Expect instructions at pcs 0 and 4 only, then `halted=1` and a constant `read_address`.
  - Redirect to 0 clears `halted` and restarts fetch.
  - Without the macro, pc 8 is delivered with `inst_data=0`.
- **Reset mid-stream:** `rst_n=0` with 3 entries buffered.
  - Expect `inst_valid=0` next cycle and a restart from `RESET_PC`.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// FETCH_HALT_ON_ZERO_EN (defined in instr_fetch) enables the stop-word halt.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;
  localparam logic [2:0] FUNCT3_LW = 3'b010;

  typedef enum logic {
    FETCH  = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  // Clear the byte-offset bits of an address.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Show-ahead FIFO of {pc, inst} entries with flush and an exposed count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  fetch_entry_t i_push_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [CW-1:0] o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;

  // Pop while empty is ignored.
  assign w_pop = i_pop && (r_count != '0);

  // Storage, pointers and occupancy; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_push_entry;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, issues word reads with 1-cycle
// latency, buffers {pc, inst} in a FIFO and flushes on redirect.
// Optional: define FETCH_HALT_ON_ZERO_EN to stop fetching on a zero word.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] read_address,
  output logic [2:0]      funct3,
  output logic            write_mem,
  input  logic [XLEN-1:0] read_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            halted
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_fetch_pc;
  logic            r_pend;
  logic [XLEN-1:0] r_pend_pc;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_inflight;
  logic            w_issue;
  logic            w_capture;
  logic            w_stop;
  logic            w_push;
  fetch_entry_t    w_entry;
  fetch_entry_t    w_head;

  // Credit check: buffered plus in-flight words must stay below DEPTH.
  assign w_inflight = {1'b0, w_count} + (CW+1)'(r_pend);
  assign w_issue    = (r_state == FETCH) && !redirect_valid
                      && (w_inflight < (CW+1)'(DEPTH));
  // Late responses after a halt are dropped along with the stop word.
  assign w_capture  = r_pend && !redirect_valid && (r_state == FETCH);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign w_stop = w_capture && (read_data == '0);
  assign halted = (r_state == HALTED);
`else
  assign w_stop = 1'b0;
  assign halted = 1'b0;
`endif

  assign w_push  = w_capture && !w_stop;
  assign w_entry = '{pc: r_pend_pc, inst: read_data};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: halt on a stop word, redirect always resumes fetching.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      FETCH:   if (w_stop) w_state_nxt = HALTED;
      HALTED:  w_state_nxt = HALTED;
      default: w_state_nxt = FETCH;
    endcase
    if (redirect_valid) begin
      w_state_nxt = FETCH;
    end
  end

  // Fetch PC and in-flight tracking; redirect has top priority.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_pc  <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= align_word(redirect_pc);
      r_pend     <= 1'b0;
    end else if (w_issue) begin
      r_pend     <= 1'b1;
      r_pend_pc  <= r_fetch_pc;
      r_fetch_pc <= r_fetch_pc + PC_STEP;
    end else begin
      r_pend     <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_push       (w_push),
    .i_push_entry (w_entry),
    .i_pop        (inst_ready),
    .i_flush      (redirect_valid),
    .o_head       (w_head),
    .o_count      (w_count)
  );

  assign read_address = r_fetch_pc;
  assign funct3       = FUNCT3_LW;
  assign write_mem    = 1'b0;
  assign inst_valid   = (w_count != '0);
  assign inst_data    = w_head.inst;
  assign inst_pc      = w_head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then randomized ready/redirect/reset
// traffic checked every cycle against a stream-level model of the fetch unit.
module tb_instr_fetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] read_address;
  logic [2:0]  funct3;
  logic        write_mem;
  logic [31:0] read_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;

  int total = 0;
  int bad   = 0;
  bit stop_mode = 1'b0;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .read_address   (read_address),
    .funct3         (funct3),
    .write_mem      (write_mem),
    .read_data      (read_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory image: three fixed words at 0/4/8, hashed nonzero words elsewhere.
  function automatic logic [31:0] memword(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0010_0093;
      32'h4:   return 32'h0020_0113;
      32'h8:   return stop_mode ? 32'h0 : 32'h0030_0193;
      default: return ((a * 32'h9E37_79B1) ^ 32'h5BD1_E995) | 32'h1;
    endcase
  endfunction

  // Memory with one cycle of latency.
  logic [31:0] mem_addr_q;
  always begin
    @(negedge clk);
    mem_addr_q = read_address;
    @(posedge clk);
    #1;
    read_data = memword(mem_addr_q);
  end

  // Stream-level reference: next expected head pc, cycles since restart.
  logic [31:0] exp_pc, prev_ra, prev_tgt;
  bit          started = 1'b0;
  bit          prev_rst, prev_redir, prev_halted;
  int          age, age_out;

  always @(negedge clk) begin
    if (!started) begin
      if (rst_n === 1'b0) begin
        started     = 1'b1;
        age         = 0;
        exp_pc      = RESET_PC;
        prev_rst    = 1'b1;
        prev_redir  = 1'b0;
        prev_halted = 1'b0;
        prev_ra     = RESET_PC;
        prev_tgt    = '0;
      end
    end else begin
      age_out = (age < 1000) ? age + 1 : age;
      chk("funct3", 32'(funct3), 32'h2);
      chk("write_mem", 32'(write_mem), 32'h0);
`ifndef FETCH_HALT_ON_ZERO_EN
      chk("halted_const", 32'(halted), 32'h0);
`endif
      // After a restart the stream is empty for two cycles, then never starves.
      if (age_out <= 2) chk("valid_gap", 32'(inst_valid), 32'h0);
      else if (halted !== 1'b1) chk("valid_stream", 32'(inst_valid), 32'h1);
      if (inst_valid === 1'b1) begin
        chk("head_pc", inst_pc, exp_pc);
        chk("head_data", inst_data, memword(exp_pc));
      end
      if (prev_rst) chk("ra_after_reset", read_address, RESET_PC);
      else if (prev_redir) chk("ra_after_redirect", read_address, prev_tgt);
      else if (prev_halted) chk("ra_hold_halted", read_address, prev_ra);
      else chk("ra_step", 32'(read_address == prev_ra || read_address == prev_ra + 32'd4), 32'h1);
      chk("ra_credit", 32'((read_address - exp_pc) <= 32'(4 * DEPTH)), 32'h1);

      if (!rst_n) begin
        exp_pc = RESET_PC;
        age    = 0;
      end else if (redirect_valid) begin
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        age    = 0;
      end else begin
        if (inst_valid && inst_ready) exp_pc = exp_pc + 32'd4;
        age = age_out;
      end
      prev_rst    = !rst_n;
      prev_redir  = rst_n && redirect_valid;
      prev_tgt    = redirect_pc & 32'hFFFF_FFFC;
      prev_ra     = read_address;
      prev_halted = halted;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; read_data = '0;
    @(negedge clk);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_ra", read_address, RESET_PC);
    chk("rst_pc", inst_pc, 32'h0);
    chk("rst_data", inst_data, 32'h0);
    tick();
    rst_n = 1'b1;                               // cycle 0
    tick(); tick(); @(negedge clk);             // cycle 2
    chk("first_valid", 32'(inst_valid), 32'h1);
    chk("first_pc", inst_pc, 32'h0);
    chk("first_data", inst_data, 32'h0010_0093);
    tick(); @(negedge clk);
    chk("stream_pc4", inst_pc, 32'h4);
    tick(); @(negedge clk);
    chk("stream_pc8", inst_pc, 32'h8);
    chk("stream_data8", inst_data, 32'h0030_0193);

    // Backpressure: ten cycles without ready.
    tick(); inst_ready = 1'b0;
    do_redirect(32'h0);
    repeat (9) tick();
    inst_ready = 1'b1;
    @(negedge clk);
    chk("bp_ra_freeze", read_address, 32'h10);
    chk("bp_pc0", inst_pc, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      tick(); @(negedge clk);
      chk("bp_order", inst_pc, 32'(4 * i));
    end

    // Redirect with three buffered entries and one read in flight.
    tick(); inst_ready = 1'b0;
    do_redirect(32'h0);
    repeat (4) tick();
    inst_ready = 1'b1;
    do_redirect(32'h103);
    @(negedge clk);
    chk("redir_ra", read_address, 32'h100);
    chk("redir_gap1", 32'(inst_valid), 32'h0);
    tick(); @(negedge clk);
    chk("redir_gap2", 32'(inst_valid), 32'h0);
    tick(); @(negedge clk);
    chk("redir_valid", 32'(inst_valid), 32'h1);
    chk("redir_pc", inst_pc, 32'h100);
    tick(); @(negedge clk);
    chk("redir_pc_next", inst_pc, 32'h104);

    // Address wrap.
    tick();
    do_redirect(32'hFFFF_FFFC);
    tick(); tick(); @(negedge clk);
    chk("wrap_pc_top", inst_pc, 32'hFFFF_FFFC);
    tick(); @(negedge clk);
    chk("wrap_pc_zero", inst_pc, 32'h0);

    // Stop word at address 8.
    tick();
    do_redirect(32'h0);
    stop_mode = 1'b1;
    tick(); tick(); @(negedge clk);
    chk("stop_pc0", inst_pc, 32'h0);
    tick(); @(negedge clk);
    chk("stop_pc4", inst_pc, 32'h4);
    tick(); @(negedge clk);
`ifdef FETCH_HALT_ON_ZERO_EN
    chk("stop_halted", 32'(halted), 32'h1);
    chk("stop_empty", 32'(inst_valid), 32'h0);
    repeat (3) tick();
    @(negedge clk);
    chk("stop_ra_hold", read_address, 32'h10);
    chk("stop_still_halted", 32'(halted), 32'h1);
`else
    chk("zero_word_valid", 32'(inst_valid), 32'h1);
    chk("zero_word_pc", inst_pc, 32'h8);
    chk("zero_word_data", inst_data, 32'h0);
`endif
    tick();
    do_redirect(32'h0);
    stop_mode = 1'b0;
    @(negedge clk);
    chk("restart_halted", 32'(halted), 32'h0);
    chk("restart_ra", read_address, 32'h0);
    tick(); tick(); @(negedge clk);
    chk("restart_pc", inst_pc, 32'h0);
    chk("restart_data", inst_data, 32'h0010_0093);

    // Reset with three entries buffered.
    tick(); inst_ready = 1'b0;
    do_redirect(32'h40);
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(inst_valid), 32'h0);
    chk("midrst_pc", inst_pc, 32'h0);
    chk("midrst_data", inst_data, 32'h0);
    chk("midrst_ra", read_address, RESET_PC);
    inst_ready = 1'b1;
    tick(); tick(); @(negedge clk);
    chk("midrst_restart_pc", inst_pc, RESET_PC);

    // Randomized traffic.
    repeat (3000) begin
      tick();
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      inst_ready     = ($urandom_range(0, 3) != 0);
      rst_n          = ($urandom_range(0, 299) != 0);
    end
    tick();
    rst_n = 1'b1; redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (5) tick();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
